// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package fetch_pkg;

  localparam int          INST_W   = 32;
  localparam logic [31:0] NOP_INST = 32'h0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INST_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with single-cycle flush; head is read combinationally.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign valid   = !empty;
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (Reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage is not reset; count gates every read, so stale words are never visible.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Prefetch queue: one-outstanding sequential fetch engine feeding an in-order FIFO to IF/ID.
module inst_fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        Redirect,
  input  logic [31:0] Redirect_PC,
  input  logic        Keep,
  output logic        Mem_req,
  output logic [31:0] Mem_addr,
  input  logic        Mem_ack,
  input  logic [31:0] Mem_inst,
  output logic        Inst_valid,
  output logic [31:0] Inst_IF,
  output logic [31:0] PC_IF,
  output logic [31:0] PCP4_IF,
  output logic        Full,
  output logic        Empty
);

  localparam logic [31:0] WORD_MASK = ~32'h3;

  fetch_state_e state, state_nxt;
  logic [31:0]  fetch_pc, fetch_pc_nxt;
  logic         mem_req_nxt;
  logic [31:0]  mem_addr_nxt;
  logic         ack_ok;
  logic         push;
  logic         pop;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;
  logic         fifo_valid;
  logic         fifo_full;
  logic         fifo_empty;

  // An ack only means something while a request is actually on the port.
  assign ack_ok = Mem_ack && Mem_req;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    mem_req_nxt  = Mem_req;
    mem_addr_nxt = Mem_addr;
    push         = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!Redirect && !fifo_full) begin
          mem_req_nxt  = 1'b1;
          mem_addr_nxt = fetch_pc;
          state_nxt    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ack_ok) begin
          mem_req_nxt = 1'b0;
          state_nxt   = S_IDLE;
          if (!Redirect) begin
            push         = 1'b1;
            fetch_pc_nxt = fetch_pc + 32'd4;
          end
        end else if (Redirect) begin
          // Request stays on the bus with its old address until memory answers.
          state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (ack_ok) begin
          mem_req_nxt = 1'b0;
          state_nxt   = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (Redirect) fetch_pc_nxt = Redirect_PC & WORD_MASK;
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC & WORD_MASK;
      Mem_req  <= 1'b0;
      Mem_addr <= RESET_PC & WORD_MASK;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      Mem_req  <= mem_req_nxt;
      Mem_addr <= mem_addr_nxt;
    end
  end

  assign push_entry = '{pc: Mem_addr, inst: Mem_inst};
  assign pop        = fifo_valid && !Keep;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk       (clk),
    .Reset     (Reset),
    .flush     (Redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .valid     (fifo_valid),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign Inst_valid = fifo_valid;
  assign Inst_IF    = fifo_valid ? head_entry.inst : NOP_INST;
  assign PC_IF      = fifo_valid ? head_entry.pc : 32'h0;
  assign PCP4_IF    = fifo_valid ? head_entry.pc + 32'd4 : 32'h0;
  assign Full       = fifo_full;
  assign Empty      = fifo_empty;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: zero-wait streaming, stalls, redirects, reset abandon, PC wrap.
module tb_inst_fetch_queue;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        Reset;
  logic        Redirect;
  logic [31:0] Redirect_PC;
  logic        Keep;
  logic        Mem_req;
  logic [31:0] Mem_addr;
  logic        Mem_ack;
  logic [31:0] Mem_inst;
  logic        Inst_valid;
  logic [31:0] Inst_IF;
  logic [31:0] PC_IF;
  logic [31:0] PCP4_IF;
  logic        Full;
  logic        Empty;

  logic        ack_tie;
  logic        ack_man;
  int          errors = 0;
  int          checks = 0;
  int          nreq;
  logic        got_req;
  logic [31:0] exp_pc;
  logic [31:0] exp_addr;
  logic [31:0] first_req;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  assign Mem_ack  = ack_tie ? Mem_req : ack_man;
  assign Mem_inst = mem_word(Mem_addr);

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .Reset       (Reset),
    .Redirect    (Redirect),
    .Redirect_PC (Redirect_PC),
    .Keep        (Keep),
    .Mem_req     (Mem_req),
    .Mem_addr    (Mem_addr),
    .Mem_ack     (Mem_ack),
    .Mem_inst    (Mem_inst),
    .Inst_valid  (Inst_valid),
    .Inst_IF     (Inst_IF),
    .PC_IF       (PC_IF),
    .PCP4_IF     (PCP4_IF),
    .Full        (Full),
    .Empty       (Empty)
  );

  task automatic check(input string tag, input logic ok,
                       input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds an already-visible request for two more cycles, acking in the third.
  task automatic slow_ack(input logic [31:0] a);
    step();
    check("slow_hold1_req", Mem_req === 1'b1, 32'(Mem_req), 32'h1);
    check("slow_hold1_addr", Mem_addr === a, Mem_addr, a);
    step();
    check("slow_hold2_addr", Mem_addr === a, Mem_addr, a);
    ack_man = 1'b1;
    step();
    ack_man = 1'b0;
    check("slow_done_req", Mem_req === 1'b0, 32'(Mem_req), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; Redirect = 1'b0; Redirect_PC = 32'h0; Keep = 1'b0;
    ack_tie = 1'b0; ack_man = 1'b0;
    step();
    step();

    // Reset state
    check("rst_req", Mem_req === 1'b0, 32'(Mem_req), 32'h0);
    check("rst_addr", Mem_addr === 32'h0, Mem_addr, 32'h0);
    check("rst_valid", Inst_valid === 1'b0, 32'(Inst_valid), 32'h0);
    check("rst_empty", Empty === 1'b1, 32'(Empty), 32'h1);
    check("rst_full", Full === 1'b0, 32'(Full), 32'h0);
    check("rst_inst_nop", Inst_IF === 32'h0, Inst_IF, 32'h0);
    check("rst_pc", PC_IF === 32'h0, PC_IF, 32'h0);
    check("rst_pcp4", PCP4_IF === 32'h0, PCP4_IF, 32'h0);

    // 1: zero-wait stream, no stall
    ack_tie = 1'b1;
    Reset = 1'b0;
    exp_addr = 32'h0;
    exp_pc = 32'h0;
    repeat (16) begin
      step();
      if (Mem_req) begin
        check("t1_addr", Mem_addr === exp_addr, Mem_addr, exp_addr);
        check("t1_align", Mem_addr[1:0] === 2'b00, 32'(Mem_addr[1:0]), 32'h0);
        exp_addr = exp_addr + 32'd4;
      end
      if (Inst_valid) begin
        check("t1_pc", PC_IF === exp_pc, PC_IF, exp_pc);
        check("t1_inst", Inst_IF === mem_word(exp_pc), Inst_IF, mem_word(exp_pc));
        check("t1_pcp4", PCP4_IF === exp_pc + 32'd4, PCP4_IF, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
      end
    end
    check("t1_progress", exp_pc >= 32'h10, exp_pc, 32'h10);

    // 2: stall from reset fills the queue, then drain
    Reset = 1'b1; Keep = 1'b1;
    step();
    Reset = 1'b0;
    nreq = 0;
    repeat (12) begin
      step();
      if (Mem_req) begin
        check("t2_addr", Mem_addr === 32'(nreq * 4), Mem_addr, 32'(nreq * 4));
        nreq++;
      end
    end
    check("t2_nreq", nreq == 4, 32'(nreq), 32'h4);
    check("t2_full", Full === 1'b1, 32'(Full), 32'h1);
    check("t2_not_empty", Empty === 1'b0, 32'(Empty), 32'h0);
    check("t2_req_idle", Mem_req === 1'b0, 32'(Mem_req), 32'h0);
    check("t2_head_pc", PC_IF === 32'h0, PC_IF, 32'h0);
    Keep = 1'b0;
    exp_pc = 32'h0;
    got_req = 1'b0;
    first_req = 32'hFFFF_FFFF;
    repeat (5) begin
      check("t2_drain_valid", Inst_valid === 1'b1, 32'(Inst_valid), 32'h1);
      check("t2_drain_pc", PC_IF === exp_pc, PC_IF, exp_pc);
      check("t2_drain_inst", Inst_IF === mem_word(exp_pc), Inst_IF, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      step();
      if (Mem_req && !got_req) begin
        first_req = Mem_addr;
        got_req = 1'b1;
      end
    end
    check("t2_resume_seen", got_req === 1'b1, 32'(got_req), 32'h1);
    check("t2_resume_addr", first_req === 32'h10, first_req, 32'h10);

    // 3: redirect while a slow request to 0x8 is outstanding
    Reset = 1'b1; Keep = 1'b1; ack_tie = 1'b0; ack_man = 1'b0;
    step();
    Reset = 1'b0;
    step();
    check("t3_req0", Mem_req === 1'b1, 32'(Mem_req), 32'h1);
    check("t3_addr0", Mem_addr === 32'h0, Mem_addr, 32'h0);
    slow_ack(32'h0);
    step();
    check("t3_addr4", Mem_addr === 32'h4, Mem_addr, 32'h4);
    slow_ack(32'h4);
    step();
    check("t3_req8", Mem_req === 1'b1, 32'(Mem_req), 32'h1);
    check("t3_addr8", Mem_addr === 32'h8, Mem_addr, 32'h8);
    check("t3_head_pre", PC_IF === 32'h0, PC_IF, 32'h0);
    step();
    Redirect = 1'b1; Redirect_PC = 32'h100;
    step();
    Redirect = 1'b0;
    check("t3_flushed", Empty === 1'b1, 32'(Empty), 32'h1);
    check("t3_drop_state", dut.state === S_DROP, 32'(dut.state), 32'(S_DROP));
    check("t3_drop_req", Mem_req === 1'b1, 32'(Mem_req), 32'h1);
    check("t3_drop_addr", Mem_addr === 32'h8, Mem_addr, 32'h8);
    ack_man = 1'b1;
    step();
    ack_man = 1'b0;
    check("t3_dropped_req", Mem_req === 1'b0, 32'(Mem_req), 32'h0);
    check("t3_dropped_valid", Inst_valid === 1'b0, 32'(Inst_valid), 32'h0);
    step();
    check("t3_new_req", Mem_req === 1'b1, 32'(Mem_req), 32'h1);
    check("t3_new_addr", Mem_addr === 32'h100, Mem_addr, 32'h100);
    slow_ack(32'h100);
    check("t3_valid", Inst_valid === 1'b1, 32'(Inst_valid), 32'h1);
    check("t3_pc", PC_IF === 32'h100, PC_IF, 32'h100);
    check("t3_inst", Inst_IF === mem_word(32'h100), Inst_IF, mem_word(32'h100));

    // 4: redirect coincides with an ack, two entries queued
    step();
    check("t4_addr104", Mem_addr === 32'h104, Mem_addr, 32'h104);
    slow_ack(32'h104);
    step();
    check("t4_addr108", Mem_addr === 32'h108, Mem_addr, 32'h108);
    check("t4_two_queued", Empty === 1'b0, 32'(Empty), 32'h0);
    Redirect = 1'b1; Redirect_PC = 32'h200; ack_man = 1'b1;
    step();
    Redirect = 1'b0; ack_man = 1'b0;
    check("t4_empty", Empty === 1'b1, 32'(Empty), 32'h1);
    check("t4_valid", Inst_valid === 1'b0, 32'(Inst_valid), 32'h0);
    check("t4_req_off", Mem_req === 1'b0, 32'(Mem_req), 32'h0);
    check("t4_nop", Inst_IF === 32'h0, Inst_IF, 32'h0);
    step();
    check("t4_req", Mem_req === 1'b1, 32'(Mem_req), 32'h1);
    check("t4_addr", Mem_addr === 32'h200, Mem_addr, 32'h200);
    ack_man = 1'b1;
    step();
    ack_man = 1'b0;
    check("t4_pc", PC_IF === 32'h200, PC_IF, 32'h200);
    check("t4_inst", Inst_IF === mem_word(32'h200), Inst_IF, mem_word(32'h200));
    check("t4_pcp4", PCP4_IF === 32'h204, PCP4_IF, 32'h204);

    // 5: full queue, pop then refill, push and pop in the same cycle
    Reset = 1'b1; Keep = 1'b1; ack_tie = 1'b1;
    step();
    Reset = 1'b0;
    repeat (9) step();
    check("t5_full", Full === 1'b1, 32'(Full), 32'h1);
    check("t5_head0", PC_IF === 32'h0, PC_IF, 32'h0);
    Keep = 1'b0;
    step();
    Keep = 1'b1;
    check("t5_after_pop_full", Full === 1'b0, 32'(Full), 32'h0);
    check("t5_head4", PC_IF === 32'h4, PC_IF, 32'h4);
    step();
    check("t5_req10", Mem_req === 1'b1, 32'(Mem_req), 32'h1);
    check("t5_addr10", Mem_addr === 32'h10, Mem_addr, 32'h10);
    step();
    check("t5_refull", Full === 1'b1, 32'(Full), 32'h1);
    check("t5_head4_kept", PC_IF === 32'h4, PC_IF, 32'h4);
    repeat (3) begin
      step();
      check("t5_hold_req", Mem_req === 1'b0, 32'(Mem_req), 32'h0);
      check("t5_hold_full", Full === 1'b1, 32'(Full), 32'h1);
    end
    Keep = 1'b0;
    step();
    Keep = 1'b1;
    check("t5_head8", PC_IF === 32'h8, PC_IF, 32'h8);
    step();
    check("t5_addr14", Mem_addr === 32'h14, Mem_addr, 32'h14);
    Keep = 1'b0;
    step();
    Keep = 1'b1;
    check("t5_pushpop_head", PC_IF === 32'hC, PC_IF, 32'hC);
    check("t5_pushpop_full", Full === 1'b0, 32'(Full), 32'h0);
    step();
    check("t5_addr18", Mem_addr === 32'h18, Mem_addr, 32'h18);
    step();
    check("t5_full2", Full === 1'b1, 32'(Full), 32'h1);
    Keep = 1'b0;
    exp_pc = 32'hC;
    repeat (5) begin
      check("t5_order_pc", PC_IF === exp_pc, PC_IF, exp_pc);
      check("t5_order_inst", Inst_IF === mem_word(exp_pc), Inst_IF, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      step();
    end
    Keep = 1'b1;

    // 6: reset abandons an outstanding request; late ack ignored
    Reset = 1'b1; Keep = 1'b0; ack_tie = 1'b0; ack_man = 1'b0;
    step();
    Reset = 1'b0;
    step();
    check("t6_addr0", Mem_addr === 32'h0, Mem_addr, 32'h0);
    ack_man = 1'b1;
    step();
    ack_man = 1'b0;
    check("t6_valid0", Inst_valid === 1'b1, 32'(Inst_valid), 32'h1);
    step();
    check("t6_req4", Mem_req === 1'b1, 32'(Mem_req), 32'h1);
    check("t6_addr4", Mem_addr === 32'h4, Mem_addr, 32'h4);
    Reset = 1'b1;
    step();
    check("t6_rst_req", Mem_req === 1'b0, 32'(Mem_req), 32'h0);
    check("t6_rst_empty", Empty === 1'b1, 32'(Empty), 32'h1);
    Reset = 1'b0; ack_man = 1'b1;
    step();
    ack_man = 1'b0;
    check("t6_late_empty", Empty === 1'b1, 32'(Empty), 32'h1);
    check("t6_late_valid", Inst_valid === 1'b0, 32'(Inst_valid), 32'h0);
    check("t6_post_req", Mem_req === 1'b1, 32'(Mem_req), 32'h1);
    check("t6_post_addr", Mem_addr === 32'h0, Mem_addr, 32'h0);
    ack_man = 1'b1;
    step();
    ack_man = 1'b0;
    check("t6_post_pc", PC_IF === 32'h0, PC_IF, 32'h0);

    // 7: fetch PC wraps modulo 2^32
    Keep = 1'b1; ack_tie = 1'b1;
    Redirect = 1'b1; Redirect_PC = 32'hFFFF_FFFC;
    step();
    Redirect = 1'b0;
    check("t7_flushed", Empty === 1'b1, 32'(Empty), 32'h1);
    step();
    check("t7_addr_top", Mem_addr === 32'hFFFF_FFFC, Mem_addr, 32'hFFFF_FFFC);
    step();
    check("t7_pc_top", PC_IF === 32'hFFFF_FFFC, PC_IF, 32'hFFFF_FFFC);
    check("t7_pcp4_wrap", PCP4_IF === 32'h0, PCP4_IF, 32'h0);
    step();
    check("t7_addr_wrap", Mem_addr === 32'h0, Mem_addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
